// File: rtl/arbiter_rr_4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The master side drives requests and done; the slave side is the arbiter.
interface arbiter_rr_4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] gidx;
  logic       gvalid;
  logic       tmo;

  modport master (
    output req,
    output done,
    input  grant,
    input  gidx,
    input  gvalid,
    input  tmo
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output gidx,
    output gvalid,
    output tmo
  );
endinterface

// File: rtl/arbiter_rr_4.sv
// Four-way round-robin arbiter with a single grant held until done, request drop
// or a hold timeout, and at least one idle cycle between consecutive grants.
module arbiter_rr_4 #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst,
  arbiter_rr_4_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] grant_q;
  logic [3:0] grant_next;
  logic [1:0] gidx_q;
  logic [1:0] gidx_next;
  logic       gvalid_q;
  logic       gvalid_next;
  logic       tmo_q;
  logic       tmo_next;
  logic [1:0] ptr_q;
  logic [1:0] ptr_next;
  logic [3:0] cnt_q;
  logic [3:0] cnt_next;
  logic [1:0] winner;
  logic       any_req;
  logic       owner_req;
  logic       hit_limit;
  logic       release_any;
  logic       forced_release;

  assign any_req        = |bus.req;
  assign owner_req      = bus.req[gidx_q];
  assign hit_limit      = (cnt_q == CNT_LAST);
  assign release_any    = bus.done | ~owner_req | hit_limit;
  // Timeout only counts when nothing else would have released the grant anyway.
  assign forced_release = hit_limit & ~bus.done & owner_req;

  // Walk downward so the smallest offset from ptr+1 overwrites the rest.
  always_comb begin
    winner = ptr_q + 2'd1;
    for (int i = 4; i >= 1; i--) begin
      if (bus.req[ptr_q + 2'(i)]) begin
        winner = ptr_q + 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      gvalid_q <= 1'b0;
      tmo_q    <= 1'b0;
      ptr_q    <= 2'd3;
      cnt_q    <= '0;
    end else begin
      state    <= state_next;
      grant_q  <= grant_next;
      gidx_q   <= gidx_next;
      gvalid_q <= gvalid_next;
      tmo_q    <= tmo_next;
      ptr_q    <= ptr_next;
      cnt_q    <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (any_req)     state_next = GRANT;
      GRANT:   if (release_any) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Computes the values every registered output takes at the coming edge.
  always_comb begin
    grant_next  = '0;
    gidx_next   = gidx_q;
    gvalid_next = 1'b0;
    tmo_next    = 1'b0;
    ptr_next    = ptr_q;
    cnt_next    = '0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          grant_next  = 4'b0001 << winner;
          gidx_next   = winner;
          gvalid_next = 1'b1;
          ptr_next    = winner;
        end
      end
      GRANT: begin
        if (release_any) begin
          tmo_next = forced_release;
        end else begin
          grant_next  = grant_q;
          gvalid_next = 1'b1;
          cnt_next    = cnt_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign bus.grant  = grant_q;
  assign bus.gidx   = gidx_q;
  assign bus.gvalid = gvalid_q;
  assign bus.tmo    = tmo_q;

endmodule
